// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - Gray/binary conversion helpers and shared step-event type
package gray_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int MAX_W     = 32;

   typedef logic [MAX_W-1:0] word_t;

   typedef enum logic [1:0] {
      EV_NONE = 2'd0,
      EV_UP   = 2'd1,
      EV_DOWN = 2'd2,
      EV_ERR  = 2'd3
   } step_ev_t;

   // Zero-extended inputs decode correctly: upper zero bits add nothing to the XOR prefix.
   function automatic word_t gray2bin(input word_t g);
      word_t b;
      b = g;
      for (int s = 1; s < MAX_W; s = s * 2) begin
         b = b ^ (b >> s);
      end
      return b;
   endfunction

   function automatic word_t bin2gray(input word_t b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - one-bit multi-flop synchroniser with asynchronous active-low reset
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff <= '0;
      end else begin
         ff <= {ff[STAGES-2:0], d};
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/gray_to_binary_sync.sv
// rtl/gray_to_binary_sync.sv - synchronise a foreign Gray count, decode it and classify each change
module gray_to_binary_sync
   import gray_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int SYNC_STAGES = 2,
   parameter int ERR_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             enable,
   input  logic             err_clr,
   output logic [WIDTH-1:0] bin_out,
   output logic             bin_valid,
   output logic             step_up,
   output logic             step_down,
   output logic             step_err,
   output logic [ERR_W-1:0] err_count
);

   logic [WIDTH-1:0] g_s;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] g_ref;
   logic [WIDTH-1:0] b_ref;
   logic [WIDTH-1:0] diff;
   logic             single;
   step_ev_t         ev;

   for (genvar i = 0; i < WIDTH; i++) begin : g_sync
      bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (gray_in[i]),
         .q     (g_s[i])
      );
   end

   assign b      = WIDTH'(gray2bin(word_t'(g_s)));
   assign diff   = g_s ^ g_ref;
   assign single = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);

   always_comb begin
      ev = EV_NONE;
      if (diff != '0) begin
         if (!single) begin
            ev = EV_ERR;
         end else if (b == b_ref + WIDTH'(1)) begin
            ev = EV_UP;
         end else if (b == b_ref - WIDTH'(1)) begin
            ev = EV_DOWN;
         end
      end
   end

   // References track every cycle so changes seen while disabled never replay on re-enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g_ref <= '0;
         b_ref <= '0;
      end else begin
         g_ref <= g_s;
         b_ref <= b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_out   <= '0;
         bin_valid <= 1'b0;
         step_up   <= 1'b0;
         step_down <= 1'b0;
         step_err  <= 1'b0;
      end else begin
         bin_valid <= 1'b0;
         step_up   <= 1'b0;
         step_down <= 1'b0;
         step_err  <= 1'b0;
         if (enable && ev != EV_NONE) begin
            bin_out   <= b;
            bin_valid <= 1'b1;
            step_up   <= (ev == EV_UP);
            step_down <= (ev == EV_DOWN);
            step_err  <= (ev == EV_ERR);
         end
      end
   end

   // A clear coinciding with an error keeps that error counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= '0;
      end else if (err_clr) begin
         err_count <= (enable && ev == EV_ERR) ? ERR_W'(1) : '0;
      end else if (enable && ev == EV_ERR && err_count != {ERR_W{1'b1}}) begin
         err_count <= err_count + ERR_W'(1);
      end
   end

endmodule
